// File: rtl/mips_board_pkg.sv
// Shared constants for the MIPS board glue logic.
//   KEY_RELEASED          : raw/synchronised level of an idle (released) pushbutton
//   mode_e                : CPU clocking mode, MODE_STEP = 0, MODE_RUN = 1
//   DEBOUNCE_CYCLES_SIM   : short debounce window used in simulation
//   DEBOUNCE_CYCLES_BOARD : debounce window for the 50 MHz board build (20 ms)
//   cnt_width()           : bits needed to count 0..n-1, never less than 1
package mips_board_pkg;

  localparam logic KEY_RELEASED = 1'b1;

  typedef enum logic {
    MODE_STEP = 1'b0,
    MODE_RUN  = 1'b1
  } mode_e;

  localparam int DEBOUNCE_CYCLES_SIM   = 16;
  localparam int DEBOUNCE_CYCLES_BOARD = 1_000_000;

  function automatic int cnt_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/key_debounce.sv
// One pushbutton channel: 2-FF synchroniser, stability counter, debounced
// level and one-cycle press/release pulses.
//   clk           : system clock
//   rst_n         : asynchronous active-low reset
//   key_raw       : raw button, active-low
//   level         : debounced state, active-high (1 = pressed)
//   press_pulse   : one cycle, aligned with the first cycle level is 1
//   release_pulse : one cycle, aligned with the first cycle level is 0
module key_debounce
  import mips_board_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_SIM
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key_raw,
  output logic level,
  output logic press_pulse,
  output logic release_pulse
);

  localparam int             CW       = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0]  CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync_meta;
  logic          sync_out;
  logic          stable;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_meta     <= KEY_RELEASED;
      sync_out      <= KEY_RELEASED;
      stable        <= KEY_RELEASED;
      cnt           <= '0;
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
    end else begin
      sync_meta     <= key_raw;
      sync_out      <= sync_meta;
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
      if (sync_out != stable) begin
        // The pulses are registered together with stable so they line up
        // with the first cycle of the new level.
        if (cnt == CNT_LAST) begin
          stable        <= sync_out;
          cnt           <= '0;
          press_pulse   <= (sync_out != KEY_RELEASED);
          release_pulse <= (sync_out == KEY_RELEASED);
        end else begin
          cnt <= cnt + CW'(1);
        end
      end else begin
        // Any agreement restarts the window, so short glitches vanish.
        cnt <= '0;
      end
    end
  end

  assign level = ~stable;

endmodule

// File: rtl/key_step_ctrl.sv
// Pushbutton conditioner and CPU clock-enable generator for the MIPS board.
//   CLOCK_50    : 50 MHz system clock
//   RESET_N     : asynchronous active-low reset
//   KEY         : raw pushbuttons, active-low
//   key_level   : debounced key state, active-high
//   key_press   : one-cycle pulse per debounced press
//   key_release : one-cycle pulse per debounced release
//   run_mode    : 1 = free-run, 0 = single-step
//   cpu_en      : clock enable to the MIPS core
//   step_count  : number of cpu_en cycles issued, wrapping
//
// Mode FSM:
//   state     | meaning
//   MODE_RUN  | cpu_en every RUN_DIV-th cycle from the divider
//   MODE_STEP | cpu_en for one cycle after each STEP_KEY press
module key_step_ctrl
  import mips_board_pkg::*;
#(
  parameter int NUM_KEYS        = 4,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_SIM,
  parameter int RUN_DIV         = 1,
  parameter int STEP_KEY        = 1,
  parameter int MODE_KEY        = 2,
  parameter int RUN_AT_RESET    = 1,
  parameter int CNT_W           = 16
) (
  input  logic                CLOCK_50,
  input  logic                RESET_N,
  input  logic [NUM_KEYS-1:0] KEY,
  output logic [NUM_KEYS-1:0] key_level,
  output logic [NUM_KEYS-1:0] key_press,
  output logic [NUM_KEYS-1:0] key_release,
  output logic                run_mode,
  output logic                cpu_en,
  output logic [CNT_W-1:0]    step_count
);

  if (STEP_KEY == MODE_KEY) begin : g_err_same_key
    $error("key_step_ctrl: STEP_KEY and MODE_KEY must differ");
  end
  if (STEP_KEY >= NUM_KEYS || MODE_KEY >= NUM_KEYS || STEP_KEY < 0 || MODE_KEY < 0) begin : g_err_key_range
    $error("key_step_ctrl: STEP_KEY/MODE_KEY out of range");
  end
  if (NUM_KEYS < 2 || DEBOUNCE_CYCLES < 2 || RUN_DIV < 1) begin : g_err_params
    $error("key_step_ctrl: NUM_KEYS>=2, DEBOUNCE_CYCLES>=2, RUN_DIV>=1 required");
  end

  for (genvar i = 0; i < NUM_KEYS; i++) begin : g_key
    key_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
      .clk          (CLOCK_50),
      .rst_n        (RESET_N),
      .key_raw      (KEY[i]),
      .level        (key_level[i]),
      .press_pulse  (key_press[i]),
      .release_pulse(key_release[i])
    );
  end

  localparam int             DW        = cnt_width(RUN_DIV);
  localparam logic [DW-1:0]  DIV_LAST  = DW'(RUN_DIV - 1);
  localparam mode_e          MODE_INIT = (RUN_AT_RESET != 0) ? MODE_RUN : MODE_STEP;

  mode_e         state;
  mode_e         state_next;
  logic [DW-1:0] div;
  logic [DW-1:0] div_next;
  logic          en_next;
  logic          mode_hit;
  logic          step_hit;

  assign mode_hit = key_press[MODE_KEY];
  assign step_hit = key_press[STEP_KEY];

  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      state      <= MODE_INIT;
      div        <= '0;
      cpu_en     <= 1'b0;
      step_count <= '0;
    end else begin
      state  <= state_next;
      div    <= div_next;
      cpu_en <= en_next;
      if (cpu_en) begin
        step_count <= step_count + CNT_W'(1);
      end
    end
  end

  // cpu_en is registered so it is low during reset; en_next is derived from
  // div_next so that cpu_en is high exactly in the cycle div == DIV_LAST.
  always_comb begin
    state_next = state;
    div_next   = '0;
    en_next    = 1'b0;
    case (state)
      MODE_RUN: begin
        if (mode_hit) begin
          // A mode toggle wins over a coincident step press.
          state_next = MODE_STEP;
        end else begin
          div_next = (div == DIV_LAST) ? '0 : div + DW'(1);
          en_next  = (div_next == DIV_LAST);
        end
      end
      MODE_STEP: begin
        if (mode_hit) begin
          state_next = MODE_RUN;
          en_next    = (DIV_LAST == '0);
        end else begin
          en_next = step_hit;
        end
      end
      default: begin
        state_next = MODE_INIT;
      end
    endcase
  end

  assign run_mode = (state == MODE_RUN);

endmodule

// File: tb/tb_key_step_ctrl.sv
module tb_key_step_ctrl;

  localparam int NK   = 4;
  localparam int DEB  = 4;
  localparam int RDIV = 3;
  localparam int CW   = 4;
  localparam int SK   = 1;
  localparam int MK   = 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [NK-1:0] key = '1;
  logic [NK-1:0] key_level, key_press, key_release;
  logic          run_mode, cpu_en;
  logic [CW-1:0] step_count;

  always #5 clk = ~clk;

  key_step_ctrl #(
    .NUM_KEYS(NK), .DEBOUNCE_CYCLES(DEB), .RUN_DIV(RDIV), .STEP_KEY(SK),
    .MODE_KEY(MK), .RUN_AT_RESET(1), .CNT_W(CW)
  ) dut (
    .CLOCK_50(clk), .RESET_N(rst_n), .KEY(key),
    .key_level(key_level), .key_press(key_press), .key_release(key_release),
    .run_mode(run_mode), .cpu_en(cpu_en), .step_count(step_count)
  );

  typedef struct packed {
    logic [NK-1:0] level;
    logic [NK-1:0] press;
    logic [NK-1:0] rel;
    logic          run;
    logic          en;
    logic [CW-1:0] cnt;
  } obs_t;

  obs_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  // Reference model: a key's accepted level flips once its synchronised
  // sample (raw input two edges old) has disagreed for DEB consecutive edges.
  // Run mode enables on every RDIV-th cycle counted from the first cycle of
  // run mode (the reset cycle counts as that first cycle).
  logic [NK-1:0] m_acc, m_h1, m_h2, m_press, m_rel;
  int            m_run [NK];
  logic          m_mode, m_en;
  int            m_n, m_cnt;

  task automatic model_reset();
    m_acc = '1; m_h1 = '1; m_h2 = '1;
    m_press = '0; m_rel = '0;
    for (int k = 0; k < NK; k++) m_run[k] = 0;
    m_mode = 1'b1; m_n = 1; m_en = 1'b0; m_cnt = 0;
  endtask

  task automatic model_edge(input logic [NK-1:0] raw);
    logic [NK-1:0] s, old_acc;
    obs_t o;
    m_cnt = (m_cnt + (m_en ? 1 : 0)) % (1 << CW);
    if (m_press[MK]) begin
      m_mode = !m_mode;
      m_n    = 1;
      m_en   = m_mode && ((m_n % RDIV) == 0);
    end else if (m_mode) begin
      m_n  = m_n + 1;
      m_en = ((m_n % RDIV) == 0);
    end else begin
      m_en = m_press[SK];
    end
    s = m_h2; m_h2 = m_h1; m_h1 = raw;
    old_acc = m_acc;
    for (int k = 0; k < NK; k++) begin
      if (s[k] != m_acc[k]) begin
        m_run[k] = m_run[k] + 1;
        if (m_run[k] == DEB) begin
          m_acc[k] = s[k];
          m_run[k] = 0;
        end
      end else begin
        m_run[k] = 0;
      end
    end
    m_press = old_acc & ~m_acc;
    m_rel   = ~old_acc & m_acc;
    o.level = ~m_acc; o.press = m_press; o.rel = m_rel;
    o.run = m_mode; o.en = m_en; o.cnt = CW'(m_cnt);
    exp_q.push_back(o);
  endtask

  obs_t mon_e, mon_a;
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      mon_a = {key_level, key_press, key_release, run_mode, cpu_en, step_count};
      n_checks++;
      if (mon_a !== mon_e) begin
        n_fail++;
        $display("FAIL outputs t=%0t: got lvl=%b prs=%b rel=%b run=%b en=%b cnt=%0d, want lvl=%b prs=%b rel=%b run=%b en=%b cnt=%0d",
                 $time, mon_a.level, mon_a.press, mon_a.rel, mon_a.run, mon_a.en, mon_a.cnt,
                 mon_e.level, mon_e.press, mon_e.rel, mon_e.run, mon_e.en, mon_e.cnt);
      end
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h", name, got, want);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) begin
      @(posedge clk);
      model_edge(key);
      #1;
    end
  endtask

  task automatic hold(input logic [NK-1:0] k, input int n);
    key = k;
    cycles(n);
  endtask

  task automatic reset_checks(input string tag);
    check({tag, "_cnt"},   32'(step_count), 32'd0);
    check({tag, "_en"},    32'(cpu_en), 32'd0);
    check({tag, "_level"}, 32'(key_level), 32'd0);
    check({tag, "_press"}, 32'(key_press | key_release), 32'd0);
    check({tag, "_run"},   32'(run_mode), 32'd1);
  endtask

  // Called at posedge+1: asserts reset after the pending check was consumed.
  task automatic do_reset(input string tag);
    #5;
    rst_n = 1'b0;
    #1;
    reset_checks(tag);
    @(posedge clk);
    @(negedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();
  endtask

  int start_cnt;

  initial begin : stim
    logic [NK-1:0] k;
    model_reset();
    key = 4'b1011;
    @(posedge clk);
    @(negedge clk);
    #1;
    reset_checks("reset_init");
    rst_n = 1'b1;
    model_reset();

    // KEY[2] held through reset: press after the debounce latency -> step mode
    cycles(12);
    check("mode_after_key2", 32'(run_mode), 32'd0);
    hold('1, 10);

    // glitches on the step key
    hold(4'b1101, 3);
    hold('1, 10);
    hold(4'b1101, 8);
    hold('1, 12);

    // held step key: one enable only
    hold(4'b1101, 20);
    hold('1, 10);

    // back to run mode, then simultaneous mode+step presses
    hold(4'b1011, 8);
    hold('1, 15);
    check("run_before_both", 32'(run_mode), 32'd1);
    hold(4'b1001, 10);
    hold('1, 10);
    check("mode_after_both", 32'(run_mode), 32'd0);

    // divided run rate from reset
    do_reset("reset_run");
    hold('1, 30);
    check("run_div_count", 32'((step_count >= 4'd9) && (step_count <= 4'd11)), 32'd1);

    // step mode and 17 step presses (count wraps)
    hold(4'b1011, 8);
    hold('1, 8);
    start_cnt = m_cnt;
    for (int i = 0; i < 17; i++) begin
      hold(4'b1101, 7);
      hold('1, 7);
    end
    check("step_wrap", 32'(step_count), 32'((start_cnt + 17) % 16));

    // reset in the middle of a step sequence
    hold(4'b1011, 8);
    hold('1, 8);
    for (int i = 0; i < 9; i++) begin
      hold(4'b1101, 7);
      hold('1, 7);
    end
    do_reset("reset_mid");
    hold('1, 10);

    // random key activity
    for (int i = 0; i < 400; i++) begin
      k = '1;
      if ($urandom_range(0, 2) != 0) k[$urandom_range(0, NK-1)] = 1'b0;
      if ($urandom_range(0, 5) == 0) k[$urandom_range(0, NK-1)] = 1'b0;
      hold(k, $urandom_range(1, 10));
      if ($urandom_range(0, 150) == 0) do_reset("reset_rand");
    end
    hold('1, 20);

    @(negedge clk);
    #1;
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
